// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants, flag type and forwarding helper for the LEGv8 pipeline
package cpu_pkg;

    localparam int XLEN = 64;

    localparam logic [2:0] ALU_PASSB = 3'b000;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_SUB   = 3'b011;
    localparam logic [2:0] ALU_AND   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;
    localparam logic [2:0] ALU_XOR   = 3'b110;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } flags_t;

    // Select 11 is never produced by the forwarding unit; treat it as no-forward.
    function automatic logic [XLEN-1:0] fwd_mux(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] reg_val,
        input logic [XLEN-1:0] wb_val,
        input logic [XLEN-1:0] mem_val
    );
        logic [XLEN-1:0] r;
        case (sel)
            FWD_WB:  r = wb_val;
            FWD_MEM: r = mem_val;
            default: r = reg_val;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu64.sv
// rtl/alu64.sv - combinational 64-bit ALU with N/Z/V/C flag generation
module alu64
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      alu_op,
    output logic [XLEN-1:0] result,
    output logic            negative,
    output logic            zero,
    output logic            overflow,
    output logic            carry_out
);

    logic            is_sub;
    logic            is_arith;
    logic [XLEN-1:0] b_eff;
    logic [XLEN:0]   sum;

    // Subtraction reuses the adder as a + ~b + 1 so carry means "no borrow".
    always_comb begin
        is_sub   = (alu_op == ALU_SUB);
        is_arith = (alu_op == ALU_ADD) || is_sub;
        b_eff    = is_sub ? ~b : b;
        sum      = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, is_sub};

        case (alu_op)
            ALU_PASSB:        result = b;
            ALU_ADD, ALU_SUB: result = sum[XLEN-1:0];
            ALU_AND:          result = a & b;
            ALU_OR:           result = a | b;
            ALU_XOR:          result = a ^ b;
            default:          result = '0;
        endcase

        negative  = result[XLEN-1];
        zero      = (result == '0);
        carry_out = is_arith & sum[XLEN];
        overflow  = is_arith & (a[XLEN-1] == b_eff[XLEN-1]) & (result[XLEN-1] != a[XLEN-1]);
    end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - EX stage: operand forwarding, ALU, BL link mux and condition flag register
module execute_stage
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] ReadData1,
    input  logic [XLEN-1:0] ReadData2,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] ALU_or_DT,
    input  logic [XLEN-1:0] alu_result_mem,
    input  logic [XLEN-1:0] alu_result_wb,
    input  logic [2:0]      ALUop,
    input  logic            ALUsrc,
    input  logic            update,
    input  logic            cbz_id,
    input  logic            BLsignal,
    input  logic [1:0]      forwardA,
    input  logic [1:0]      forwardB,
    input  logic [XLEN-1:0] BLT,
    output logic [XLEN-1:0] alu_result,
    output logic            negative,
    output logic            zero,
    output logic            overflow,
    output logic            carry_out
);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] op_b;
    logic [2:0]      op_sel;
    logic [XLEN-1:0] alu_out;
    flags_t          live_flags;
    flags_t          stored_flags;
    flags_t          out_flags;
    logic            unused_pc;

    // PC only rides along the pipeline; nothing in EX consumes it.
    assign unused_pc = ^PC;

    assign op_a   = fwd_mux(forwardA, ReadData1, alu_result_wb, alu_result_mem);
    assign fwd_b  = fwd_mux(forwardB, ReadData2, alu_result_wb, alu_result_mem);
    assign op_b   = ALUsrc ? ALU_or_DT : fwd_b;
    assign op_sel = cbz_id ? ALU_PASSB : ALUop;

    alu64 u_alu (
        .a         (op_a),
        .b         (op_b),
        .alu_op    (op_sel),
        .result    (alu_out),
        .negative  (live_flags.n),
        .zero      (live_flags.z),
        .overflow  (live_flags.v),
        .carry_out (live_flags.c)
    );

    // Flags always reflect the ALU, even when BL replaces the stage result.
    assign alu_result = BLsignal ? BLT : alu_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stored_flags <= '0;
        end else if (update) begin
            stored_flags <= live_flags;
        end
    end

    // Bypass lets a B.cond in decode see flags from the ADDS/SUBS now in EX.
    assign out_flags = update ? live_flags : stored_flags;

    assign negative  = out_flags.n;
    assign zero      = out_flags.z;
    assign overflow  = out_flags.v;
    assign carry_out = out_flags.c;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed scoreboard bench for execute_stage
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] ReadData1, ReadData2, PC, ALU_or_DT;
    logic [63:0] alu_result_mem, alu_result_wb, BLT;
    logic [2:0]  ALUop;
    logic        ALUsrc, update, cbz_id, BLsignal;
    logic [1:0]  forwardA, forwardB;
    logic [63:0] alu_result;
    logic        negative, zero, overflow, carry_out;

    typedef struct {
        string       tag;
        logic [63:0] res;
        logic [3:0]  flags;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    execute_stage dut (
        .clk            (clk),
        .reset          (reset),
        .ReadData1      (ReadData1),
        .ReadData2      (ReadData2),
        .PC             (PC),
        .ALU_or_DT      (ALU_or_DT),
        .alu_result_mem (alu_result_mem),
        .alu_result_wb  (alu_result_wb),
        .ALUop          (ALUop),
        .ALUsrc         (ALUsrc),
        .update         (update),
        .cbz_id         (cbz_id),
        .BLsignal       (BLsignal),
        .forwardA       (forwardA),
        .forwardB       (forwardB),
        .BLT            (BLT),
        .alu_result     (alu_result),
        .negative       (negative),
        .zero           (zero),
        .overflow       (overflow),
        .carry_out      (carry_out)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input string tag, input logic [63:0] res, input logic [3:0] flags);
        exp_t e;
        e.tag   = tag;
        e.res   = res;
        e.flags = flags;
        exp_q.push_back(e);
    endtask

    // Pops the oldest expectation and compares it against the live outputs.
    task automatic check_out();
        exp_t       e;
        logic [3:0] obs_flags;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL scoreboard_empty observed=0 required=1");
        end else begin
            e = exp_q.pop_front();
            obs_flags = {negative, zero, overflow, carry_out};
            n_cmp++;
            assert (alu_result === e.res) else begin
                n_err++;
                $error("FAIL %s_result observed=%h required=%h", e.tag, alu_result, e.res);
            end
            n_cmp++;
            assert (obs_flags === e.flags) else begin
                n_err++;
                $error("FAIL %s_flags(NZVC) observed=%b required=%b", e.tag, obs_flags, e.flags);
            end
        end
    endtask

    task automatic step(input string tag, input logic [63:0] res, input logic [3:0] flags);
        push_exp(tag, res, flags);
        #1;
        check_out();
    endtask

    initial begin
        reset = 1'b0;
        ReadData1 = '0; ReadData2 = '0; PC = 64'h400; ALU_or_DT = '0;
        alu_result_mem = '0; alu_result_wb = '0; BLT = '0;
        ALUop = 3'b000; ALUsrc = 1'b0; update = 1'b0; cbz_id = 1'b0; BLsignal = 1'b0;
        forwardA = 2'b00; forwardB = 2'b00;

        @(negedge clk);
        step("reset_state", 64'd0, 4'b0000);
        reset = 1'b1;

        // Forwarding
        @(negedge clk);
        ReadData1 = 64'd5; alu_result_mem = 64'd7; alu_result_wb = 64'd9; ReadData2 = 64'd1;
        ALUop = 3'b010; forwardA = 2'b10;
        step("fwd_a_mem", 64'd8, 4'b0000);
        @(negedge clk);
        forwardA = 2'b01;
        step("fwd_a_wb", 64'd10, 4'b0000);
        @(negedge clk);
        forwardA = 2'b00; forwardB = 2'b10;
        step("fwd_b_mem", 64'd12, 4'b0000);
        @(negedge clk);
        forwardA = 2'b11; forwardB = 2'b11;
        step("fwd_11_none", 64'd6, 4'b0000);

        // SUBS with immediate: borrow
        @(negedge clk);
        forwardA = 2'b00; forwardB = 2'b00;
        ReadData1 = 64'd3; ALU_or_DT = 64'd5; ALUsrc = 1'b1; ALUop = 3'b011; update = 1'b1;
        step("subs_borrow", 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
        @(negedge clk);
        update = 1'b0; ALUop = 3'b000; ALU_or_DT = 64'd0;
        step("flags_held", 64'd0, 4'b1000);

        // ADDS overflow then carry
        @(negedge clk);
        ReadData1 = 64'h7FFF_FFFF_FFFF_FFFF; ALU_or_DT = 64'd1; ALUop = 3'b010; update = 1'b1;
        step("adds_ovf", 64'h8000_0000_0000_0000, 4'b1010);
        @(negedge clk);
        ReadData1 = 64'hFFFF_FFFF_FFFF_FFFF;
        step("adds_carry", 64'd0, 4'b0101);

        // CBZ forces pass-B; Z is live only with update
        @(negedge clk);
        update = 1'b0; cbz_id = 1'b1; ALUsrc = 1'b0; ReadData1 = 64'd5; ReadData2 = 64'd0;
        step("cbz_no_update", 64'd0, 4'b0101);
        @(negedge clk);
        update = 1'b1;
        step("cbz_update", 64'd0, 4'b0100);

        // BL substitutes the link address; flags still from ALU
        @(negedge clk);
        cbz_id = 1'b0; update = 1'b0; BLsignal = 1'b1; BLT = 64'h104;
        step("bl_link", 64'h104, 4'b0100);
        @(negedge clk);
        update = 1'b1; ALUop = 3'b000; ALUsrc = 1'b1; ALU_or_DT = 64'h8000_0000_0000_0000;
        step("bl_flags_alu", 64'h104, 4'b1000);

        // Async reset mid-cycle clears stored flags
        @(negedge clk);
        BLsignal = 1'b0; ReadData1 = 64'd3; ALU_or_DT = 64'd5; ALUop = 3'b011; update = 1'b1;
        step("subs_pre_reset", 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
        @(negedge clk);
        update = 1'b0;
        #1;
        step("stored_before_reset", 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
        reset = 1'b0;
        step("async_reset", 64'hFFFF_FFFF_FFFF_FFFE, 4'b0000);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        step("post_reset_hold", 64'hFFFF_FFFF_FFFF_FFFE, 4'b0000);

        // Logic ops and undefined encodings
        @(negedge clk);
        ALUsrc = 1'b0; ReadData1 = 64'hF0; ReadData2 = 64'h3C; update = 1'b1; ALUop = 3'b100;
        step("and", 64'h30, 4'b0000);
        @(negedge clk);
        ALUop = 3'b101;
        step("or", 64'hFC, 4'b0000);
        @(negedge clk);
        ALUop = 3'b110;
        step("xor", 64'hCC, 4'b0000);
        @(negedge clk);
        ALUop = 3'b001;
        step("op001", 64'd0, 4'b0100);
        @(negedge clk);
        ALUop = 3'b111; update = 1'b0;
        step("op111_stored", 64'd0, 4'b0100);

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL scoreboard_leftover observed=%0d required=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 5-stage pipelined 64-bit LEGv8 CPU, placed between the ID/EX and EX/MEM pipeline registers. It selects forwarded operands, performs the ALU operation, and substitutes the link address for BL. It also holds the architectural condition flags (N, Z, V, C) and makes them visible to the decode stage for conditional branches. The datapath is combinational; the flag register is the only state.

## Interface
Parameters:
- none (data width fixed at 64)

Ports:
- clk  in  1  system clock; flags update on rising edge
- reset  in  1  asynchronous, active-low; low clears flag register
- ReadData1  in  64  register-file value for Rn (from ID/EX)
- ReadData2  in  64  register-file value for Rm/Rt (from ID/EX)
- PC  in  64  instruction PC; carried through, no functional effect
- ALU_or_DT  in  64  sign/zero-extended immediate or DT offset
- alu_result_mem  in  64  forwarding source from EX/MEM
- alu_result_wb  in  64  forwarding source from MEM/WB
- ALUop  in  3  operation select
- ALUsrc  in  1  1 = operand B is ALU_or_DT
- update  in  1  1 = instruction sets flags (ADDS/SUBS)
- cbz_id  in  1  1 = CBZ in EX; forces pass-B
- BLsignal  in  1  1 = result is BLT (link address)
- forwardA  in  2  operand-A forwarding select
- forwardB  in  2  operand-B forwarding select
- BLT  in  64  link address (PC+4) for BL
- alu_result  out  64  stage result to EX/MEM
- negative, zero, overflow, carry_out  out  1 each  flag outputs

## Operation
- Forwarded A:
  - forwardA 00 → ReadData1
  - 01 → alu_result_wb
  - 10 → alu_result_mem
  - 11 → ReadData1
- Forwarded B: same encoding on ReadData2 with forwardB.
- Operand B = ALUsrc ? ALU_or_DT : forwarded B.
- ALUop, applied to forwarded A and operand B:
  - 000 pass B
  - 010 A+B
  - 011 A−B, computed as A+~B+1
  - 100 AND
  - 101 OR
  - 110 XOR
  - 001 and 111 → result 0
- cbz_id=1 overrides ALUop to pass B.
- Live flags, from the ALU result:
  - N = result[63]
  - Z = (result == 0)
  - C = carry out of bit 63 for add/sub, else 0
  - V = signed overflow for add/sub, i.e. operands' sign bits equal and result sign differs (subtract uses ~B), else 0
- alu_result = BLsignal ? BLT : ALU result. Live flags always come from the ALU result, never from BLT.
- Flag register: on a rising clk edge with update=1, load the live N/Z/V/C; otherwise hold.
- Flag outputs = update ? live flags : stored flags. This bypass lets a B.cond in ID see the flags of the ADDS/SUBS currently in EX.
- All arithmetic is modulo 2^64; no exceptions.

## Timing
- alu_result and live flags are purely combinational from the inputs (zero-cycle latency).
- Stored flags change only at a rising clk edge with update=1. They are visible the same cycle through the bypass and from the next cycle through the register.
- reset low: flag register cleared immediately, asynchronously. While reset is low and update=0, all four flag outputs read 0. alu_result is unaffected by reset.
- Reset released mid-operation: the flag register resumes loading at the first rising edge with reset high and update=1.
- forwardA/forwardB = 11 is never generated by the forwarding unit; it is defined as no-forward.

## Structure
- Shared package `cpu_pkg` holds:
  - ALUop constants: ALU_PASSB, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR
  - forwarding select constants: FWD_NONE, FWD_WB, FWD_MEM
- One sub-module, `alu64`, a combinational 64-bit ALU producing result, N, Z, V, C.
- The top level contains the forwarding muxes, the operand-B/imm mux, the BL mux, and the flag register with bypass.

## Test plan
- Forwarding: ReadData1=5, alu_result_mem=7, alu_result_wb=9, ReadData2=1, ALUop=010, ALUsrc=0 → forwardA=10 gives 8; forwardA=01 gives 10; forwardB=10 with forwardA=00 gives 12.
- Immediate / SUBS borrow: A=3, ALU_or_DT=5, ALUsrc=1, ALUop=011, update=1 → result 0xFFFF_FFFF_FFFF_FFFE, N=1, Z=0, C=0, V=0. Next cycle with update=0, the flags still read N=1.
- Overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, ADDS → result 0x8000_0000_0000_0000, V=1, N=1, C=0. Then A=0xFFFF_FFFF_FFFF_FFFF, B=1, ADDS → 0, Z=1, C=1, V=0.
- CBZ/BL: cbz_id=1, ALUop=010, ReadData2=0 → result 0, Z live only if update=1. BLsignal=1, BLT=0x104 → alu_result=0x104.
- Reset: after SUBS sets N=1, drive reset low mid-cycle → flags read 0 immediately without a clock edge. Release reset, then update=0 → flags stay 0.
- Logic ops: A=0xF0, B=0x3C → AND 0x30, OR 0xFC, XOR 0xCC. ALUop=001 → 0, with C=V=0 throughout.
